// File: rtl/irq_controller_if.sv
// Interrupt controller bus: request/boundary inputs from the core, status and vector outputs to fetch/regfile.
// Purely combinational bundle; no flow control.
interface irq_controller_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0] irq;
  logic            cycle;
  logic [15:0]     pc;
  logic            ei;
  logic            di;
  logic            rti;
  logic            istatus;
  logic            ienabled;
  logic [15:0]     intRA;
  logic            take;
  logic [15:0]     vec;
  logic [2:0]      cause;
  logic [NIRQ-1:0] pending;

  modport master (
    output irq, cycle, pc, ei, di, rti,
    input  istatus, ienabled, intRA, take, vec, cause, pending
  );

  modport slave (
    input  irq, cycle, pc, ei, di, rti,
    output istatus, ienabled, intRA, take, vec, cause, pending
  );
endinterface

// File: rtl/irq_controller.sv
// Synchronises external interrupt lines, latches edges and enters an interrupt at instruction boundaries.
// irq rise to pending bit: 3 clocks; pending to take: next boundary; no backpressure, requests merge while pending.
module irq_controller #(
  parameter int          NIRQ      = 4,
  parameter logic [15:0] VEC_BASE  = 16'h0100,
  parameter int          VEC_SHIFT = 2
) (
  input logic            clk,
  input logic            nclr,
  irq_controller_if.slave bus
);

  logic [NIRQ-1:0] s1, s2, s3;
  logic [NIRQ-1:0] req_edge;
  logic [NIRQ-1:0] clear;
  logic [NIRQ-1:0] pending_q;
  logic            istatus_q;
  logic            ienabled_q;
  logic            take_q;
  logic [2:0]      cause_q;
  logic [15:0]     intra_q;
  logic [2:0]      win;
  logic            go;
  logic [15:0]     cause_ext;

  assign req_edge = s2 & ~s3;
  assign go       = bus.cycle & ienabled_q & ~istatus_q & (|pending_q);

  // Scan downward so the lowest-numbered pending line is the winner.
  always_comb begin
    win = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) win = 3'(i);
    end
  end

  always_comb begin
    clear = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clear[i] = go & (win == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      pending_q  <= '0;
      istatus_q  <= 1'b0;
      ienabled_q <= 1'b0;
      take_q     <= 1'b0;
      cause_q    <= 3'd0;
      intra_q    <= 16'h0000;
    end else begin
      s1 <= bus.irq;
      s2 <= s1;
      s3 <= s2;
      // A fresh edge on the line being taken survives the clear.
      pending_q <= (pending_q & ~clear) | req_edge;
      take_q    <= go;
      if (go) begin
        istatus_q <= 1'b1;
        cause_q   <= win;
      end else if (bus.cycle && istatus_q && bus.rti) begin
        istatus_q <= 1'b0;
      end
      if (bus.cycle && !istatus_q) intra_q <= bus.pc;
      if (bus.cycle) begin
        if (bus.di)      ienabled_q <= 1'b0;
        else if (bus.ei) ienabled_q <= 1'b1;
      end
    end
  end

  assign cause_ext    = {13'd0, cause_q};
  assign bus.vec      = VEC_BASE + (cause_ext << VEC_SHIFT);
  assign bus.istatus  = istatus_q;
  assign bus.ienabled = ienabled_q;
  assign bus.intRA    = intra_q;
  assign bus.take     = take_q;
  assign bus.cause    = cause_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: latency, priority, enable ordering, collisions, async reset, merging.
module tb_irq_controller;
  logic clk = 1'b0;
  logic nclr = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  irq_controller_if #(.NIRQ(4)) bus ();

  irq_controller #(.NIRQ(4), .VEC_BASE(16'h0100), .VEC_SHIFT(2)) dut (
    .clk (clk),
    .nclr(nclr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic boundary(input logic [15:0] p, input logic e, input logic d, input logic r);
    bus.cycle = 1'b1; bus.pc = p; bus.ei = e; bus.di = d; bus.rti = r;
    tick();
    bus.cycle = 1'b0; bus.ei = 1'b0; bus.di = 1'b0; bus.rti = 1'b0;
  endtask

  task automatic test_reset();
    bus.irq = 4'b0; bus.cycle = 1'b0; bus.pc = 16'h0; bus.ei = 1'b0; bus.di = 1'b0; bus.rti = 1'b0;
    nclr = 1'b0;
    tick(3);
    #2 nclr = 1'b1;
    tick();
    vecs++; if (bus.istatus !== 1'b0) begin errs++; $display("FAIL rst_istatus got=%0h exp=0", bus.istatus); end
    vecs++; if (bus.ienabled !== 1'b0) begin errs++; $display("FAIL rst_ienabled got=%0h exp=0", bus.ienabled); end
    vecs++; if (bus.take !== 1'b0) begin errs++; $display("FAIL rst_take got=%0h exp=0", bus.take); end
    vecs++; if (bus.cause !== 3'd0) begin errs++; $display("FAIL rst_cause got=%0h exp=0", bus.cause); end
    vecs++; if (bus.pending !== 4'b0) begin errs++; $display("FAIL rst_pending got=%b exp=0000", bus.pending); end
    vecs++; if (bus.intRA !== 16'h0) begin errs++; $display("FAIL rst_intRA got=%h exp=0000", bus.intRA); end
    vecs++; if (bus.vec !== 16'h0100) begin errs++; $display("FAIL rst_vec got=%h exp=0100", bus.vec); end
  endtask

  task automatic test_latency();
    boundary(16'h0000, 1'b1, 1'b0, 1'b0);
    vecs++; if (bus.ienabled !== 1'b1) begin errs++; $display("FAIL lat_ei got=%0h exp=1", bus.ienabled); end
    bus.irq = 4'b0100;
    tick(2);
    vecs++; if (bus.pending !== 4'b0000) begin errs++; $display("FAIL lat_pending_early got=%b exp=0000", bus.pending); end
    tick();
    vecs++; if (bus.pending !== 4'b0100) begin errs++; $display("FAIL lat_pending got=%b exp=0100", bus.pending); end
    bus.irq = 4'b0;
    boundary(16'h1234, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL lat_take got=%0h exp=1", bus.take); end
    vecs++; if (bus.vec !== 16'h0108) begin errs++; $display("FAIL lat_vec got=%h exp=0108", bus.vec); end
    vecs++; if (bus.cause !== 3'd2) begin errs++; $display("FAIL lat_cause got=%0d exp=2", bus.cause); end
    vecs++; if (bus.istatus !== 1'b1) begin errs++; $display("FAIL lat_istatus got=%0h exp=1", bus.istatus); end
    vecs++; if (bus.intRA !== 16'h1234) begin errs++; $display("FAIL lat_intRA got=%h exp=1234", bus.intRA); end
    vecs++; if (bus.pending !== 4'b0000) begin errs++; $display("FAIL lat_pending_clr got=%b exp=0000", bus.pending); end
    tick();
    vecs++; if (bus.take !== 1'b0) begin errs++; $display("FAIL lat_take_pulse got=%0h exp=0", bus.take); end
    boundary(16'h5555, 1'b0, 1'b0, 1'b1);
    vecs++; if (bus.istatus !== 1'b0) begin errs++; $display("FAIL lat_rti got=%0h exp=0", bus.istatus); end
    vecs++; if (bus.intRA !== 16'h1234) begin errs++; $display("FAIL lat_intRA_frozen got=%h exp=1234", bus.intRA); end
  endtask

  task automatic test_priority();
    bus.irq = 4'b1010;
    tick(3);
    bus.irq = 4'b0;
    vecs++; if (bus.pending !== 4'b1010) begin errs++; $display("FAIL pri_pending got=%b exp=1010", bus.pending); end
    boundary(16'h2000, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL pri_take1 got=%0h exp=1", bus.take); end
    vecs++; if (bus.vec !== 16'h0104) begin errs++; $display("FAIL pri_vec1 got=%h exp=0104", bus.vec); end
    vecs++; if (bus.pending !== 4'b1000) begin errs++; $display("FAIL pri_left got=%b exp=1000", bus.pending); end
    boundary(16'h2004, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b0) begin errs++; $display("FAIL pri_nested got=%0h exp=0", bus.take); end
    vecs++; if (bus.intRA !== 16'h2000) begin errs++; $display("FAIL pri_intRA got=%h exp=2000", bus.intRA); end
    boundary(16'h2008, 1'b0, 1'b0, 1'b1);
    vecs++; if (bus.istatus !== 1'b0) begin errs++; $display("FAIL pri_rti got=%0h exp=0", bus.istatus); end
    vecs++; if (bus.take !== 1'b0) begin errs++; $display("FAIL pri_rti_take got=%0h exp=0", bus.take); end
    boundary(16'h2010, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL pri_take3 got=%0h exp=1", bus.take); end
    vecs++; if (bus.vec !== 16'h010C) begin errs++; $display("FAIL pri_vec3 got=%h exp=010c", bus.vec); end
    vecs++; if (bus.cause !== 3'd3) begin errs++; $display("FAIL pri_cause3 got=%0d exp=3", bus.cause); end
    boundary(16'h2014, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_enable_order();
    boundary(16'h3000, 1'b0, 1'b1, 1'b0);
    vecs++; if (bus.ienabled !== 1'b0) begin errs++; $display("FAIL en_di got=%0h exp=0", bus.ienabled); end
    bus.irq = 4'b0001;
    tick(3);
    bus.irq = 4'b0;
    boundary(16'h3004, 1'b1, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b0) begin errs++; $display("FAIL en_ei_same got=%0h exp=0", bus.take); end
    vecs++; if (bus.ienabled !== 1'b1) begin errs++; $display("FAIL en_ei got=%0h exp=1", bus.ienabled); end
    boundary(16'h3008, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL en_ei_next got=%0h exp=1", bus.take); end
    vecs++; if (bus.vec !== 16'h0100) begin errs++; $display("FAIL en_vec got=%h exp=0100", bus.vec); end
    boundary(16'h300C, 1'b0, 1'b0, 1'b1);
    bus.irq = 4'b0100;
    tick(3);
    bus.irq = 4'b0;
    boundary(16'h3010, 1'b0, 1'b1, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL en_di_same got=%0h exp=1", bus.take); end
    vecs++; if (bus.ienabled !== 1'b0) begin errs++; $display("FAIL en_di_clr got=%0h exp=0", bus.ienabled); end
    boundary(16'h3014, 1'b0, 1'b0, 1'b1);
    boundary(16'h3018, 1'b1, 1'b1, 1'b0);
    vecs++; if (bus.ienabled !== 1'b0) begin errs++; $display("FAIL en_both got=%0h exp=0", bus.ienabled); end
    boundary(16'h301C, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    bus.irq = 4'b0001;
    tick(3);
    bus.irq = 4'b0;
    tick(3);
    bus.irq = 4'b0001;
    tick(2);
    boundary(16'h4000, 1'b0, 1'b0, 1'b0);
    bus.irq = 4'b0;
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL col_take got=%0h exp=1", bus.take); end
    vecs++; if (bus.pending !== 4'b0001) begin errs++; $display("FAIL col_pending got=%b exp=0001", bus.pending); end
    boundary(16'h4004, 1'b0, 1'b0, 1'b1);
    boundary(16'h4008, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL col_retake got=%0h exp=1", bus.take); end
    vecs++; if (bus.pending !== 4'b0000) begin errs++; $display("FAIL col_drained got=%b exp=0000", bus.pending); end
    boundary(16'h400C, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    bus.irq = 4'b1000;
    tick(3);
    bus.irq = 4'b0;
    boundary(16'hBEEF, 1'b0, 1'b0, 1'b0);
    bus.irq = 4'b0010;
    tick(3);
    bus.irq = 4'b0;
    vecs++; if (bus.istatus !== 1'b1) begin errs++; $display("FAIL mr_pre_istatus got=%0h exp=1", bus.istatus); end
    vecs++; if (bus.pending !== 4'b0010) begin errs++; $display("FAIL mr_pre_pending got=%b exp=0010", bus.pending); end
    vecs++; if (bus.intRA !== 16'hBEEF) begin errs++; $display("FAIL mr_pre_intRA got=%h exp=beef", bus.intRA); end
    #1 nclr = 1'b0;
    #1;
    vecs++; if (bus.istatus !== 1'b0) begin errs++; $display("FAIL mr_istatus got=%0h exp=0", bus.istatus); end
    vecs++; if (bus.ienabled !== 1'b0) begin errs++; $display("FAIL mr_ienabled got=%0h exp=0", bus.ienabled); end
    vecs++; if (bus.pending !== 4'b0) begin errs++; $display("FAIL mr_pending got=%b exp=0000", bus.pending); end
    vecs++; if (bus.intRA !== 16'h0) begin errs++; $display("FAIL mr_intRA got=%h exp=0000", bus.intRA); end
    vecs++; if (bus.cause !== 3'd0) begin errs++; $display("FAIL mr_cause got=%0d exp=0", bus.cause); end
    vecs++; if (bus.vec !== 16'h0100) begin errs++; $display("FAIL mr_vec got=%h exp=0100", bus.vec); end
    #1 nclr = 1'b1;
    tick();
  endtask

  task automatic test_held_level();
    int takes;
    boundary(16'h5000, 1'b1, 1'b0, 1'b0);
    bus.irq = 4'b0010;
    tick(3);
    boundary(16'h5004, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b1) begin errs++; $display("FAIL hl_take got=%0h exp=1", bus.take); end
    tick(46);
    vecs++; if (bus.pending !== 4'b0) begin errs++; $display("FAIL hl_level_once got=%b exp=0000", bus.pending); end
    for (int p = 0; p < 2; p++) begin
      bus.irq = 4'b0;
      tick(3);
      bus.irq = 4'b0010;
      tick(2);
    end
    bus.irq = 4'b0;
    tick(3);
    vecs++; if (bus.pending !== 4'b0010) begin errs++; $display("FAIL hl_merged got=%b exp=0010", bus.pending); end
    boundary(16'h5008, 1'b0, 1'b0, 1'b0);
    vecs++; if (bus.take !== 1'b0) begin errs++; $display("FAIL hl_in_service got=%0h exp=0", bus.take); end
    boundary(16'h500C, 1'b0, 1'b0, 1'b1);
    takes = 0;
    for (int b = 0; b < 6; b++) begin
      boundary(16'h5010 + 16'(b * 4), 1'b0, 1'b0, (b == 0));
      if (bus.take === 1'b1) takes++;
      tick(2);
    end
    vecs++; if (takes !== 1) begin errs++; $display("FAIL hl_take_count got=%0d exp=1", takes); end
    vecs++; if (bus.pending !== 4'b0) begin errs++; $display("FAIL hl_final_pending got=%b exp=0000", bus.pending); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_enable_order();
    test_collision();
    test_mid_reset();
    test_held_level();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
